assoc_reconfig_ctrl: RTL and testbench
======================================

// Module: assoc_reconfig_ctrl
// PURPOSE
//  Responder side of the setup_valid/setup_update/setup_ready associativity-change handshake.
//  The associativity predictor initiates each request; this block services it.
//  - Holds the live cache configuration `setup` (0..SETUP_MAX).
//  - On a legal request: stalls the cache, sweeps every line (writeback dirty, invalidate),
//    then commits setup+1 (upscale) or setup-1 (downscale) and acknowledges.
//  - Sits between the predictor and the mutative cache datapath/controller.
// PARAMETERS
//  SET_SIZE    16  sets per way; power of 2
//  WAYS        4   physical ways; power of 2
//  SETUP_MAX   3   highest legal setup code
//  SETUP_RESET 0   setup value after reset
// PORTS
//  clk           in   1               clock, rising edge
//  rst_n         in   1               reset, asynchronous, active-low
//  setup_valid   in   1               request from predictor; held until setup_ready
//  setup_update  in   1               0 = upscale (setup+1), 1 = downscale (setup-1)
//  setup         out  2               current configuration, to cache and predictor
//  setup_ready   out  1               one-cycle acknowledge
//  cache_idle    in   1               cache has no outstanding CPU/memory transaction
//  cache_hold    out  1               cache must not accept new CPU requests
//  flush_valid   out  1               line flush request
//  flush_set     out  $clog2(SET_SIZE) set index of flush request
//  flush_way     out  $clog2(WAYS)     way index of flush request
//  flush_ready   in   1               cache completed flush of the presented line
//  reconfig_cnt  out  16              committed changes; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Outputs: setup=SETUP_RESET; setup_ready=0, cache_hold=0, flush_valid=0,
//     flush_set=0, flush_way=0, reconfig_cnt=0.
//   - State S_IDLE.
//   - Takes effect immediately, including mid-sweep; any partial sweep is abandoned.
//  FSM states: S_IDLE, S_DRAIN, S_FLUSH, S_COMMIT, S_REJECT, S_GUARD.
//  S_IDLE: samples setup_valid.
//   - Legal request: (update=0 and setup<SETUP_MAX) or (update=1 and setup>0).
//     Latch direction, go to S_DRAIN.
//   - Illegal request: go to S_REJECT.
//  S_DRAIN:
//   - cache_hold=1; flush_valid=0.
//   - When cache_idle=1, go to S_FLUSH with line counter = 0.
//  S_FLUSH:
//   - cache_hold=1; flush_valid=1.
//   - flush_set/flush_way come from a registered counter: way is the low field, set the high field.
//   - Counter advances only on a cycle where flush_valid && flush_ready.
//   - While flush_ready=0, outputs hold stable.
//   - On acceptance of line (SET_SIZE-1, WAYS-1): counter wraps to 0; setup is updated
//     by ±1 on that same edge; go to S_COMMIT.
//  S_COMMIT:
//   - setup_ready=1 (new setup already visible); cache_hold=1.
//   - reconfig_cnt increments, saturating.
//   - Go to S_GUARD.
//  S_REJECT:
//   - setup_ready=1; setup unchanged; cache_hold=0; no flush.
//   - Go to S_GUARD.
//  S_GUARD:
//   - One cycle; setup_valid ignored; cache_hold=0.
//   - Go to S_IDLE. This absorbs the initiator's registered valid drop.
//  General rules:
//   - setup_ready and cache_hold are Moore outputs: decoded from state, no combinational input path.
//   - setup_update is sampled only in S_IDLE.
//   - setup_valid changes after capture are ignored.
//   - Latency, legal request, flush_ready=1 and cache_idle=1 throughout:
//     setup_ready at T+2+SET_SIZE*WAYS, where T = S_IDLE sample cycle.
//   - Latency, illegal request: setup_ready at T+1.
//   - setup never leaves 0..SETUP_MAX and changes only on the final-flush edge.
//   - cache_idle and flush_ready are ignored outside S_DRAIN and S_FLUSH respectively.
// TESTING
//  1) Reset: assert rst_n=0 with no clock edge -> outputs drop immediately to reset values;
//     setup=0.
//  2) Upscale, SET_SIZE=4, WAYS=2, idle/ready tied 1; setup_valid=1, update=0 at T
//     -> cache_hold=1 T+1..T+10;
//     flush (set,way) = (0,0),(0,1),(1,0)..(3,1) on T+2..T+9;
//     setup=1 with setup_ready=1 at T+10; reconfig_cnt=1.
//  3) Illegal: setup=3, update=0 -> setup_ready=1 at T+1; setup=3; flush_valid/cache_hold never 1.
//     Repeat with setup=0, update=1 -> same result.
//  4) Backpressure: flush_ready=0 for 3 cycles on line index 5 -> flush_set=2, flush_way=1
//     held stable, flush_valid=1; setup_ready delayed by exactly 3 cycles.
//  5) Drain: cache_idle=0 for 4 cycles after request -> stays S_DRAIN with cache_hold=1,
//     flush_valid=0; first flush exactly 1 cycle after cache_idle rises.
//  6) Reset mid-sweep (line 3, setup=1) -> flush_valid=0, cache_hold=0, setup=SETUP_RESET
//     immediately; next request restarts at line (0,0).

Source files
------------

// File: rtl/assoc_reconfig_ctrl.sv
// Services associativity-change requests from the predictor: stalls the cache,
// sweeps every line (writeback + invalidate), then commits setup +/- 1 and
// acknowledges. Illegal requests are acknowledged without touching the cache.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   setup_valid     request from predictor, held until setup_ready
//   setup_update    0 = upscale (setup+1), 1 = downscale (setup-1)
//   setup           live cache configuration
//   setup_ready     one-cycle acknowledge
//   cache_idle      cache has no outstanding transaction
//   cache_hold      cache must not accept new CPU requests
//   flush_valid     line flush request
//   flush_set/way   line being flushed
//   flush_ready     cache completed flush of the presented line
//   reconfig_cnt    committed changes, saturating
module assoc_reconfig_ctrl #(
    parameter int unsigned SET_SIZE    = 16,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned SETUP_MAX   = 3,
    parameter int unsigned SETUP_RESET = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        setup_valid,
    input  logic                        setup_update,
    output logic [1:0]                  setup,
    output logic                        setup_ready,
    input  logic                        cache_idle,
    output logic                        cache_hold,
    output logic                        flush_valid,
    output logic [$clog2(SET_SIZE)-1:0] flush_set,
    output logic [$clog2(WAYS)-1:0]     flush_way,
    input  logic                        flush_ready,
    output logic [15:0]                 reconfig_cnt
);

    localparam int unsigned SETUP_W = 2;
    localparam int unsigned SET_W   = $clog2(SET_SIZE);
    localparam int unsigned WAY_W   = $clog2(WAYS);
    localparam int unsigned LINE_W  = SET_W + WAY_W;
    localparam int unsigned CNT_W   = 16;

    localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(SET_SIZE * WAYS - 1);
    localparam logic [SETUP_W-1:0] SETUP_TOP  = SETUP_W'(SETUP_MAX);
    localparam logic [SETUP_W-1:0] SETUP_INIT = SETUP_W'(SETUP_RESET);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_COMMIT,
        S_REJECT,
        S_GUARD
    } state_t;

    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [SETUP_W-1:0]  setup_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                ready_d, hold_d, fvalid_d;
    logic                legal_c;

    // Line counter: way in the low field so consecutive flushes walk the ways of a set
    assign flush_way = line_q[WAY_W-1:0];
    assign flush_set = line_q[LINE_W-1:WAY_W];

    assign legal_c = (!setup_update && (setup < SETUP_TOP)) ||
                     ( setup_update && (setup != '0));

    // Next state, datapath updates and Moore outputs decoded from the next state
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        line_d  = line_q;
        setup_d = setup;
        cnt_d   = reconfig_cnt;

        case (state_q)
            S_IDLE: begin
                if (setup_valid) begin
                    if (legal_c) begin
                        dir_d   = setup_update;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_REJECT;
                    end
                end
            end
            S_DRAIN: begin
                if (cache_idle) begin
                    line_d  = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_ready) begin
                    if (line_q == LINE_LAST) begin
                        // Commit on the final-flush edge so setup and count are
                        // both visible in the acknowledge cycle
                        line_d  = '0;
                        setup_d = dir_q ? setup - SETUP_W'(1) : setup + SETUP_W'(1);
                        cnt_d   = (reconfig_cnt == '1) ? reconfig_cnt
                                                       : reconfig_cnt + CNT_W'(1);
                        state_d = S_COMMIT;
                    end else begin
                        line_d = line_q + LINE_W'(1);
                    end
                end
            end
            S_COMMIT: state_d = S_GUARD;
            S_REJECT: state_d = S_GUARD;
            S_GUARD:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        hold_d   = (state_d == S_DRAIN) || (state_d == S_FLUSH) || (state_d == S_COMMIT);
        fvalid_d = (state_d == S_FLUSH);
        ready_d  = (state_d == S_COMMIT) || (state_d == S_REJECT);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            line_q       <= '0;
            setup        <= SETUP_INIT;
            reconfig_cnt <= '0;
            setup_ready  <= 1'b0;
            cache_hold   <= 1'b0;
            flush_valid  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            line_q       <= line_d;
            setup        <= setup_d;
            reconfig_cnt <= cnt_d;
            setup_ready  <= ready_d;
            cache_hold   <= hold_d;
            flush_valid  <= fvalid_d;
        end
    end

endmodule

// File: tb/tb_assoc_reconfig_ctrl.sv
// Testbench for assoc_reconfig_ctrl with SET_SIZE=4, WAYS=2 (8 lines per sweep).
module tb_assoc_reconfig_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        setup_valid;
    logic        setup_update;
    logic [1:0]  setup;
    logic        setup_ready;
    logic        cache_idle;
    logic        cache_hold;
    logic        flush_valid;
    logic [1:0]  flush_set;
    logic [0:0]  flush_way;
    logic        flush_ready;
    logic [15:0] reconfig_cnt;

    assoc_reconfig_ctrl #(
        .SET_SIZE(4), .WAYS(2), .SETUP_MAX(3), .SETUP_RESET(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .setup_valid(setup_valid), .setup_update(setup_update),
        .setup(setup), .setup_ready(setup_ready),
        .cache_idle(cache_idle), .cache_hold(cache_hold),
        .flush_valid(flush_valid), .flush_set(flush_set), .flush_way(flush_way),
        .flush_ready(flush_ready), .reconfig_cnt(reconfig_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        update;
        logic        legal;
        int          drain;
        int          bp;
        logic [1:0]  exp_setup;
        logic [15:0] exp_cnt;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [1:0]  setup;
        logic [15:0] cnt;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    int         n_pass = 0;
    int         n_checks = 0;
    logic [1:0] cur_setup = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Issue one request and follow it cycle by cycle until the guard cycle ends
    task automatic do_req(input logic upd, input logic legal, input int drain, input int bp,
                          input logic [1:0] es, input logic [15:0] ec, input int el);
        exp_t e;
        int   exp_line;
        int   bp_left;
        int   first_flush;
        e.setup = es; e.cnt = ec; e.lat = el;
        sb.push_back(e);
        exp_line    = 0;
        bp_left     = bp;
        first_flush = 2 + drain;
        @(negedge clk);
        setup_valid  = 1'b1;
        setup_update = upd;
        cache_idle   = (drain == 0);
        flush_ready  = 1'b1;
        for (int k = 1; k <= el + 2; k++) begin
            @(negedge clk);
            if (k == drain + 1) cache_idle = 1'b1;
            if (flush_valid && (int'(flush_set) * 2 + int'(flush_way)) == 5 && bp_left > 0) begin
                flush_ready = 1'b0;
                bp_left--;
            end else begin
                flush_ready = 1'b1;
            end
            chk("cache_hold", 32'(cache_hold), 32'(legal && k <= el));
            chk("flush_valid", 32'(flush_valid), 32'(legal && k >= first_flush && k <= el - 1));
            chk("setup_ready", 32'(setup_ready), 32'(k == el));
            chk("setup", 32'(setup), 32'((k >= el) ? es : cur_setup));
            if (flush_valid) begin
                chk("flush_line", 32'({flush_set, flush_way}), 32'(exp_line));
                if (flush_ready) exp_line++;
            end
            if (setup_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ack_setup", 32'(setup), 32'(e.setup));
                    chk("ack_cnt", 32'(reconfig_cnt), 32'(e.cnt));
                    chk("ack_latency", 32'(k), 32'(e.lat));
                end else begin
                    chk("spurious_ready", 32'(setup_ready), 32'd0);
                end
                setup_valid = 1'b0;
            end
        end
        chk("ack_missing", 32'(sb.size()), 32'd0);
        sb.delete();
        chk("lines_flushed", 32'(exp_line), 32'(legal ? 8 : 0));
        setup_valid = 1'b0;
        cur_setup   = es;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit found;
        vecs[0] = '{1'b0, 1'b1, 0, 0, 2'd1, 16'd1, 10};
        vecs[1] = '{1'b0, 1'b1, 0, 0, 2'd2, 16'd2, 10};
        vecs[2] = '{1'b0, 1'b1, 0, 0, 2'd3, 16'd3, 10};
        vecs[3] = '{1'b0, 1'b0, 0, 0, 2'd3, 16'd3, 1};   // upscale past max
        vecs[4] = '{1'b1, 1'b1, 0, 3, 2'd2, 16'd4, 13};  // backpressure on line 5
        vecs[5] = '{1'b1, 1'b1, 4, 0, 2'd1, 16'd5, 14};  // cache busy 4 cycles
        vecs[6] = '{1'b1, 1'b1, 0, 0, 2'd0, 16'd6, 10};
        vecs[7] = '{1'b1, 1'b0, 0, 0, 2'd0, 16'd6, 1};   // downscale below 0

        rst_n = 1'b1; setup_valid = 1'b0; setup_update = 1'b0;
        cache_idle = 1'b1; flush_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_setup", 32'(setup), 32'd0);
        chk("rst_ready", 32'(setup_ready), 32'd0);
        chk("rst_hold", 32'(cache_hold), 32'd0);
        chk("rst_fvalid", 32'(flush_valid), 32'd0);
        chk("rst_fline", 32'({flush_set, flush_way}), 32'd0);
        chk("rst_cnt", 32'(reconfig_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_req(vecs[i].update, vecs[i].legal, vecs[i].drain, vecs[i].bp,
                   vecs[i].exp_setup, vecs[i].exp_cnt, vecs[i].exp_lat);

        // Reset in the middle of a sweep (setup=1, line 3 presented)
        do_req(1'b0, 1'b1, 0, 0, 2'd1, 16'd7, 10);
        @(negedge clk);
        setup_valid = 1'b1; setup_update = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (flush_valid && {flush_set, flush_way} == 3'd3) found = 1'b1;
        end
        chk("mid_line3_reached", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_fvalid", 32'(flush_valid), 32'd0);
        chk("mid_hold", 32'(cache_hold), 32'd0);
        chk("mid_setup", 32'(setup), 32'd0);
        chk("mid_cnt", 32'(reconfig_cnt), 32'd0);
        chk("mid_fline", 32'({flush_set, flush_way}), 32'd0);
        setup_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cur_setup = 2'd0;
        do_req(1'b0, 1'b1, 0, 0, 2'd1, 16'd1, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
